// File: rtl/advanced_lifo_pkg.sv
// Shared types for the advanced LIFO: per-cycle operation decode.
package advanced_lifo_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_PUSH,
    OP_PUSH_FULL,
    OP_POP,
    OP_POP_EMPTY,
    OP_REPLACE,
    OP_BYPASS
  } op_e;

  // Classify one cycle's request against the registered full/empty state.
  function automatic op_e decode_op(input logic push, input logic pop,
                                    input logic full, input logic empty);
    op_e op;
    if (push && pop)  op = empty ? OP_BYPASS : OP_REPLACE;
    else if (push)    op = full ? OP_PUSH_FULL : OP_PUSH;
    else if (pop)     op = empty ? OP_POP_EMPTY : OP_POP;
    else              op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/advanced_lifo_if.sv
// Push/pop access bus plus occupancy status of the advanced LIFO.
interface advanced_lifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LEVEL_WIDTH = $clog2(DEPTH + 1);

  logic                   write_enable;
  logic [WIDTH-1:0]       write_data;
  logic                   read_enable;
  logic [WIDTH-1:0]       read_data;
  logic                   full;
  logic                   empty;
  logic [LEVEL_WIDTH-1:0] level;
  logic                   almost_full;
  logic                   almost_empty;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output write_enable, write_data, read_enable,
    input  read_data, full, empty, level, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  write_enable, write_data, read_enable,
    output read_data, full, empty, level, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/advanced_lifo_controller.sv
// Stack pointer, level counter, overflow/underflow flags and replace/bypass steering.
module advanced_lifo_controller
  import advanced_lifo_pkg::*;
#(
  parameter int WIDTH                  = 8,
  parameter int DEPTH                  = 4,
  parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 1,
  parameter int ALMOST_EMPTY_THRESHOLD = 1,
  parameter bit OVERWRITE_OLDEST       = 1'b0,
  localparam int DEPTH_LOG2            = $clog2(DEPTH),
  localparam int LEVEL_WIDTH           = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  resetn,
  advanced_lifo_if.slave        bus,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_waddr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [DEPTH_LOG2-1:0] mem_raddr,
  input  logic [WIDTH-1:0]      mem_rdata
);
  localparam logic [DEPTH_LOG2-1:0]  PTR_LAST = DEPTH_LOG2'(DEPTH - 1);
  localparam logic [LEVEL_WIDTH-1:0] LVL_FULL = LEVEL_WIDTH'(DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] AF_TH    = LEVEL_WIDTH'(ALMOST_FULL_THRESHOLD);
  localparam logic [LEVEL_WIDTH-1:0] AE_TH    = LEVEL_WIDTH'(ALMOST_EMPTY_THRESHOLD);

  logic [DEPTH_LOG2-1:0]  top, top_inc, top_dec;
  logic [LEVEL_WIDTH-1:0] cnt;
  logic                   ovf_q, udf_q, is_full, is_empty;
  op_e                    op;

  // Explicit wrap so non-power-of-two depths stay inside the array.
  assign top_inc  = (top == PTR_LAST) ? '0 : top + 1'b1;
  assign top_dec  = (top == '0) ? PTR_LAST : top - 1'b1;
  assign is_full  = (cnt == LVL_FULL);
  assign is_empty = (cnt == '0);
  assign op       = decode_op(bus.write_enable, bus.read_enable, is_full, is_empty);

  assign mem_wdata = bus.write_data;
  assign mem_raddr = top_dec;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = top;
    case (op)
      OP_PUSH:      mem_we = 1'b1;
      OP_PUSH_FULL: mem_we = OVERWRITE_OLDEST;
      OP_REPLACE: begin
        mem_we    = 1'b1;
        mem_waddr = top_dec;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.read_data = '0;
    if (op == OP_BYPASS) bus.read_data = bus.write_data;
    else if (!is_empty)  bus.read_data = mem_rdata;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      top   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (op == OP_PUSH_FULL);
      udf_q <= (op == OP_POP_EMPTY);
      case (op)
        OP_PUSH: begin
          top <= top_inc;
          cnt <= cnt + 1'b1;
        end
        // When full, top already sits on the bottom slot, so advancing it drops the oldest.
        OP_PUSH_FULL: if (OVERWRITE_OLDEST) top <= top_inc;
        OP_POP: begin
          top <= top_dec;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.level        = cnt;
  assign bus.almost_full  = (cnt >= AF_TH);
  assign bus.almost_empty = (cnt <= AE_TH);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: rtl/simple_dual_port_ram.sv
// One write port, one read port; REGISTERED_READ=0 gives a read-before-write async read.
module simple_dual_port_ram #(
  parameter int WIDTH           = 8,
  parameter int DEPTH           = 4,
  parameter int ADDR_WIDTH      = 2,
  parameter bit REGISTERED_READ = 1'b0
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (REGISTERED_READ) begin : g_reg_rd
      always_ff @(posedge clock) rdata <= mem[raddr];
    end else begin : g_async_rd
      assign rdata = mem[raddr];
    end
  endgenerate
endmodule

// File: rtl/advanced_lifo.sv
// LIFO stack top: controller plus read-before-write RAM for the replace path.
module advanced_lifo #(
  parameter int WIDTH                  = 8,
  parameter int DEPTH                  = 4,
  parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 1,
  parameter int ALMOST_EMPTY_THRESHOLD = 1,
  parameter bit OVERWRITE_OLDEST       = 1'b0
) (
  input  logic           clock,
  input  logic           resetn,
  advanced_lifo_if.slave bus
);
  localparam int DEPTH_LOG2 = $clog2(DEPTH);

  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr, mem_raddr;
  logic [WIDTH-1:0]      mem_wdata, mem_rdata;

  advanced_lifo_controller #(
    .WIDTH                  (WIDTH),
    .DEPTH                  (DEPTH),
    .ALMOST_FULL_THRESHOLD  (ALMOST_FULL_THRESHOLD),
    .ALMOST_EMPTY_THRESHOLD (ALMOST_EMPTY_THRESHOLD),
    .OVERWRITE_OLDEST       (OVERWRITE_OLDEST)
  ) u_ctrl (
    .clock     (clock),
    .resetn    (resetn),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  simple_dual_port_ram #(
    .WIDTH           (WIDTH),
    .DEPTH           (DEPTH),
    .ADDR_WIDTH      (DEPTH_LOG2),
    .REGISTERED_READ (1'b0)
  ) u_ram (
    .clock (clock),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_advanced_lifo.sv
// Directed bench: drop-mode (a) and overwrite-mode (b) stacks driven in lockstep.
module tb_advanced_lifo;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  advanced_lifo_if #(.WIDTH(8), .DEPTH(4)) bus_a ();
  advanced_lifo_if #(.WIDTH(8), .DEPTH(4)) bus_b ();

  advanced_lifo #(.WIDTH(8), .DEPTH(4), .ALMOST_FULL_THRESHOLD(3),
                  .ALMOST_EMPTY_THRESHOLD(1), .OVERWRITE_OLDEST(1'b0))
    u_dut_a (.clock(clock), .resetn(resetn), .bus(bus_a));

  advanced_lifo #(.WIDTH(8), .DEPTH(4), .ALMOST_FULL_THRESHOLD(3),
                  .ALMOST_EMPTY_THRESHOLD(1), .OVERWRITE_OLDEST(1'b1))
    u_dut_b (.clock(clock), .resetn(resetn), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [7:0] wd, input logic re);
    bus_a.write_enable = we; bus_a.write_data = wd; bus_a.read_enable = re;
    bus_b.write_enable = we; bus_b.write_data = wd; bus_b.read_enable = re;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [7:0] fill_d [4];
  logic [7:0] pop_a  [4];
  logic [7:0] pop_b  [4];

  initial begin
    fill_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    pop_a  = '{8'h44, 8'h33, 8'h22, 8'h11};
    pop_b  = '{8'h55, 8'h44, 8'h33, 8'h22};
    drive(1'b0, 8'h00, 1'b0);
    #11;
    chk("rst level", bus_a.level, 0);
    chk("rst empty", bus_a.empty, 1);
    chk("rst full", bus_a.full, 0);
    chk("rst almost_empty", bus_a.almost_empty, 1);
    chk("rst almost_full", bus_a.almost_full, 0);
    chk("rst overflow", bus_a.overflow, 0);
    chk("rst underflow", bus_a.underflow, 0);
    chk("rst read_data", bus_a.read_data, 0);
    resetn = 1'b1;
    tick();

    // Fill both stacks
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_d[i], 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      chk("fill level", bus_a.level, i + 1);
      chk("fill top", bus_a.read_data, fill_d[i]);
      chk("fill almost_full", bus_a.almost_full, (i >= 2));
      chk("fill full", bus_a.full, (i == 3));
      chk("fill almost_empty", bus_a.almost_empty, (i == 0));
    end

    // Push when full: a drops, b overwrites the bottom entry
    drive(1'b1, 8'h55, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("ovf a pulse", bus_a.overflow, 1);
    chk("ovf b pulse", bus_b.overflow, 1);
    chk("ovf a level", bus_a.level, 4);
    chk("ovf b level", bus_b.level, 4);
    chk("ovf a top", bus_a.read_data, 8'h44);
    chk("ovf b top", bus_b.read_data, 8'h55);
    tick();
    chk("ovf a cleared", bus_a.overflow, 0);
    chk("ovf b cleared", bus_b.overflow, 0);

    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      chk("drain a data", bus_a.read_data, pop_a[i]);
      chk("drain b data", bus_b.read_data, pop_b[i]);
      tick();
      chk("drain a level", bus_a.level, 3 - i);
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("drain a empty", bus_a.empty, 1);
    chk("drain a almost_empty", bus_a.almost_empty, 1);
    chk("drain b empty", bus_b.empty, 1);
    chk("drain a no underflow", bus_a.underflow, 0);

    // Pop on empty, then back-to-back underflow
    drive(1'b0, 8'h00, 1'b1);
    chk("udf read_data", bus_a.read_data, 0);
    tick();
    chk("udf pulse", bus_a.underflow, 1);
    chk("udf level", bus_a.level, 0);
    tick();
    chk("udf back-to-back", bus_a.underflow, 1);
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk("udf cleared", bus_a.underflow, 0);

    // Replace top
    drive(1'b1, 8'hA0, 1'b0);
    tick();
    drive(1'b1, 8'hB0, 1'b1);
    chk("replace old top", bus_a.read_data, 8'hA0);
    tick();
    chk("replace level", bus_a.level, 1);
    chk("replace no overflow", bus_a.overflow, 0);
    drive(1'b0, 8'h00, 1'b1);
    chk("replace new top", bus_a.read_data, 8'hB0);
    tick();
    chk("replace drained", bus_a.level, 0);

    // Bypass on empty
    drive(1'b1, 8'hC0, 1'b1);
    chk("bypass data", bus_a.read_data, 8'hC0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("bypass level", bus_a.level, 0);
    chk("bypass no underflow", bus_a.underflow, 0);
    chk("bypass no overflow", bus_a.overflow, 0);
    chk("bypass empty", bus_a.empty, 1);

    // Replace on a full stack must not flag overflow
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_d[i], 1'b0);
      tick();
    end
    drive(1'b1, 8'h99, 1'b1);
    chk("full replace old top", bus_a.read_data, 8'h44);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("full replace overflow", bus_a.overflow, 0);
    chk("full replace level", bus_a.level, 4);
    chk("full replace new top", bus_a.read_data, 8'h99);

    // Async reset mid-stream with level 3
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("pre-reset level", bus_a.level, 3);
    resetn = 1'b0;
    #1;
    chk("async rst level", bus_a.level, 0);
    chk("async rst empty", bus_a.empty, 1);
    chk("async rst almost_full", bus_a.almost_full, 0);
    chk("async rst read_data", bus_a.read_data, 0);
    #2;
    resetn = 1'b1;
    tick();
    drive(1'b1, 8'h77, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("post-rst pop data", bus_a.read_data, 8'h77);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("post-rst level", bus_a.level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
